cycle_sequencer: RTL

- Shared sequencer for three LED fade channels. Replaces the per-channel free-running trapezoid generators with one shared step prescaler and one shared PWM counter.
- Keeps one phase counter per channel. Each channel's duty follows a trapezoid: hold-off, ramp-up, hold-on, ramp-down.
- Drives three PWM pins.
- Phase offsets can be reprogrammed at runtime via a one-entry valid/ready config port. Writes apply on a step tick.

---
 rtl/cycle_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - shared step/PWM sequencer for three trapezoid LED fade channels
module cycle_sequencer #(
    parameter int PWM_INTERVAL     = 1200,
    parameter int INC_DEC_INTERVAL = 5000,
    parameter int HOLD_OFF_INC     = 800,
    parameter int RAMP_INC         = 400,
    parameter int HOLD_ON_INC      = 800,
    parameter int STEP             = 3,
    parameter int OFFSET0          = 0,
    parameter int OFFSET1          = 800,
    parameter int OFFSET2          = 1600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_ch,
    input  logic [11:0] cfg_offset,
    output logic        tick,
    output logic [32:0] duty,
    output logic [2:0]  pwm_out
);

    localparam int P  = HOLD_OFF_INC + 2 * RAMP_INC + HOLD_ON_INC;
    localparam int PW = $clog2(INC_DEC_INTERVAL + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(INC_DEC_INTERVAL - 1);
    localparam logic [10:0]   PWM_LAST = 11'(PWM_INTERVAL - 1);
    localparam logic [11:0]   HO_END   = 12'(HOLD_OFF_INC);
    localparam logic [11:0]   RU_END   = 12'(HOLD_OFF_INC + RAMP_INC);
    localparam logic [11:0]   HN_END   = 12'(HOLD_OFF_INC + RAMP_INC + HOLD_ON_INC);
    localparam logic [11:0]   P_LAST   = 12'(P - 1);
    localparam logic [11:0]   STEP_W   = 12'(STEP);
    localparam logic [11:0]   DUTY_MAX = 12'(PWM_INTERVAL);
    localparam logic [35:0]   RST_PH   = {12'(OFFSET2 % P), 12'(OFFSET1 % P), 12'(OFFSET0 % P)};

    // Trapezoid shape: hold-off, ramp-up, hold-on, ramp-down; saturated to full duty.
    function automatic logic [10:0] duty_of(input logic [11:0] p);
        logic [11:0] v;
        if (p < HO_END)
            v = '0;
        else if (p < RU_END)
            v = (p - HO_END + 12'd1) * STEP_W;
        else if (p < HN_END)
            v = DUTY_MAX;
        else
            v = (P_LAST - p) * STEP_W;
        if (v > DUTY_MAX)
            v = DUTY_MAX;
        return v[10:0];
    endfunction

    logic [PW-1:0] prescaler;
    logic [10:0]   pwm_cnt;
    logic [11:0]   phase [3];
    logic [11:0]   next_phase [3];
    logic [10:0]   duty_r [3];
    logic          pending;
    logic [1:0]    pend_ch;
    logic [11:0]   pend_off;

    assign tick      = en && (prescaler == PRE_LAST);
    assign cfg_ready = !pending;
    assign duty      = {duty_r[2], duty_r[1], duty_r[0]};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (pending && pend_ch == 2'(i))
                next_phase[i] = pend_off;
            else if (phase[i] == P_LAST)
                next_phase[i] = '0;
            else
                next_phase[i] = phase[i] + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            pwm_out   <= '0;
            pending   <= 1'b0;
            pend_ch   <= '0;
            pend_off  <= '0;
            for (int i = 0; i < 3; i++) begin
                phase[i]  <= RST_PH[12*i +: 12];
                duty_r[i] <= duty_of(RST_PH[12*i +: 12]);
            end
        end else begin
            if (en) begin
                prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
                pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 11'd1;
            end
            for (int i = 0; i < 3; i++)
                pwm_out[i] <= en && (pwm_cnt < duty_r[i]);

            // A write is only accepted while nothing is pending, so apply and accept never collide.
            if (tick) begin
                for (int i = 0; i < 3; i++) begin
                    phase[i]  <= next_phase[i];
                    duty_r[i] <= duty_of(next_phase[i]);
                end
                pending <= 1'b0;
            end
            if (cfg_valid && !pending) begin
                pending  <= 1'b1;
                pend_ch  <= cfg_ch;
                pend_off <= (cfg_offset > P_LAST) ? P_LAST : cfg_offset;
            end
        end
    end

endmodule
